// File: rtl/skip_unit_mc.sv
// Skip decision unit: combines flag/IR microcode conditions, synchronised
// external skip requests and an armed/sticky accumulate mode into a single
// registered active-low skip output.
//
//   mode          | meaning
//   --------------+--------------------------------------------------------
//   idle          | narmed=1, nsticky=1: nskip follows rs and ex each edge
//   armed         | narmed=0, nsticky=1: a true rs latches sticky
//   armed+sticky  | narmed=0, nsticky=0: nskip held low until CLEAR
//   CLEAR (16)    | returns to idle on the same edge, overriding everything
module skip_unit_mc #(
    parameter int              IRW    = 7,
    parameter int              NEXT   = 2,
    parameter int              SYNC   = 1,
    parameter logic [NEXT-1:0] EXT_EN = '1
) (
    input  logic            clk4,
    input  logic            nreset,
    input  logic [IRW-1:0]  ir,
    input  logic [4:0]      cond,
    input  logic            fn,
    input  logic            fz,
    input  logic            fl,
    input  logic            fv,
    input  logic [NEXT-1:0] nskipext,
    output logic            nskip,
    output logic            nsticky,
    output logic            narmed
);

    localparam logic [4:0] COND_V     = 5'd10;
    localparam logic [4:0] COND_L     = 5'd11;
    localparam logic [4:0] COND_Z     = 5'd12;
    localparam logic [4:0] COND_N     = 5'd13;
    localparam logic [4:0] COND_OP2   = 5'd15;
    localparam logic [4:0] COND_CLEAR = 5'd16;
    localparam logic [4:0] COND_ARM   = 5'd17;

    // Synchroniser chain per external channel; stage 0 samples the raw pins.
    logic [NEXT-1:0] sync_q [0:SYNC];

    logic rs;
    logic ex;
    logic sticky;
    logic armed;
    logic sticky_next;
    logic armed_next;

    // IR bits above ir[6] are deliberately ignored by the decode.
    logic unused_ir;
    assign unused_ir = ^ir;

    // Raw flag/IR skip term, decoded from the microcode condition select.
    always_comb begin
        rs = 1'b0;
        case (cond)
            5'd1:     rs = ir[0];
            5'd2:     rs = ir[1];
            5'd3:     rs = ir[2];
            5'd4:     rs = ir[3];
            5'd5:     rs = ir[4];
            5'd6:     rs = ir[5];
            5'd7:     rs = ir[6];
            COND_V:   rs = fv;
            COND_L:   rs = fl;
            COND_Z:   rs = fz;
            COND_N:   rs = fn;
            COND_OP2: rs = (|(ir[3:0] & {fn, fz, fl, fv})) ^ ir[4];
            default:  rs = 1'b0;
        endcase
    end

    // Shift external requests through the synchroniser; reset parks them idle.
    always_ff @(posedge clk4 or negedge nreset) begin
        if (!nreset) begin
            for (int i = 0; i <= SYNC; i++) begin
                sync_q[i] <= '1;
            end
        end else begin
            sync_q[0] <= nskipext;
            for (int i = 1; i <= SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
        end
    end

    assign ex     = |(~sync_q[SYNC] & EXT_EN);
    assign sticky = ~nsticky;
    assign armed  = ~narmed;

    // Next-state for the accumulate mode; CLEAR wins over both ARM and set.
    always_comb begin
        armed_next  = armed;
        sticky_next = sticky | (armed & rs);
        if (cond == COND_ARM) begin
            armed_next = 1'b1;
        end
        if (cond == COND_CLEAR) begin
            armed_next  = 1'b0;
            sticky_next = 1'b0;
        end
    end

    // Registered outputs; the status registers are held active-low directly.
    always_ff @(posedge clk4 or negedge nreset) begin
        if (!nreset) begin
            nskip   <= 1'b1;
            nsticky <= 1'b1;
            narmed  <= 1'b1;
        end else begin
            nskip   <= ~(rs | ex | sticky_next);
            nsticky <= ~sticky_next;
            narmed  <= ~armed_next;
        end
    end

endmodule

// File: tb/tb_skip_unit_mc.sv
// Scoreboard bench for skip_unit_mc: the stimulus process pushes the
// expected {nskip,nsticky,narmed} for each edge it drives; a monitor pops
// and compares shortly after every rising edge.
module tb_skip_unit_mc;

    logic       clk4 = 1'b0;
    logic       nreset = 1'b0;
    logic [8:0] ir = '0;
    logic [4:0] cond = '0;
    logic       fn = 1'b0;
    logic       fz = 1'b0;
    logic       fl = 1'b0;
    logic       fv = 1'b0;
    logic [2:0] nskipext = '1;
    logic       nskip;
    logic       nsticky;
    logic       narmed;

    typedef struct {
        logic [2:0] exp;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    skip_unit_mc #(
        .IRW    (9),
        .NEXT   (3),
        .SYNC   (1),
        .EXT_EN (3'b011)
    ) dut (
        .clk4     (clk4),
        .nreset   (nreset),
        .ir       (ir),
        .cond     (cond),
        .fn       (fn),
        .fz       (fz),
        .fl       (fl),
        .fv       (fv),
        .nskipext (nskipext),
        .nskip    (nskip),
        .nsticky  (nsticky),
        .narmed   (narmed)
    );

    always #5 clk4 = ~clk4;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    // Monitor: pop one expectation per rising edge while any are pending.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk4);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_cmp++;
                if ({nskip, nsticky, narmed} !== e.exp) begin
                    n_bad++;
                    $display("FAIL %s: got %b expected %b (nskip,nsticky,narmed)",
                             e.name, {nskip, nsticky, narmed}, e.exp);
                end
            end
        end
    end

    // Asynchronous check used only while no edge is involved.
    task automatic check_now(input logic [2:0] e, input string nm);
        n_cmp++;
        if ({nskip, nsticky, narmed} !== e) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (nskip,nsticky,narmed)",
                     nm, {nskip, nsticky, narmed}, e);
        end
    endtask

    // Drive one cycle of inputs (called at a falling edge), queue the result.
    task automatic step(input logic [4:0] c, input logic [8:0] i,
                        input logic [3:0] f, input logic [2:0] x,
                        input logic [2:0] e, input string nm);
        exp_t t;
        cond = c;
        ir = i;
        {fn, fz, fl, fv} = f;
        nskipext = x;
        t.exp = e;
        t.name = nm;
        sb.push_back(t);
        @(negedge clk4);
    endtask

    function automatic logic op2_rs(input logic [4:0] i, input logic [3:0] f);
        return (|(i[3:0] & f)) ^ i[4];
    endfunction

    initial begin
        logic [8:0] ir_v;
        // Scenario 1: reset hold with active requests, then release.
        cond = 5'd10;
        fv = 1'b1;
        nskipext = 3'b000;
        repeat (3) @(negedge clk4);
        check_now(3'b111, "rst_hold");
        nreset = 1'b1;
        step(5'd10, 9'h000, 4'b0001, 3'b000, 3'b011, "rst_flag_first_edge");
        step(5'd0,  9'h000, 4'b0000, 3'b000, 3'b111, "rst_ext_edge2");
        step(5'd0,  9'h000, 4'b0000, 3'b000, 3'b011, "rst_ext_edge3");

        // Scenario 2: external latency, release, fresh fall, disabled channel.
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b011, "ext_rel_k");
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b011, "ext_rel_k1");
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b111, "ext_rel_k2");
        step(5'd0, 9'h000, 4'b0000, 3'b110, 3'b111, "ext0_fall_k");
        step(5'd0, 9'h000, 4'b0000, 3'b110, 3'b111, "ext0_fall_k1");
        step(5'd0, 9'h000, 4'b0000, 3'b110, 3'b011, "ext0_fall_k2");
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b011, "ext0_rel_k");
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b011, "ext0_rel_k1");
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b111, "ext0_rel_k2");
        step(5'd0, 9'h000, 4'b0000, 3'b101, 3'b111, "ext1_fall_k");
        step(5'd0, 9'h000, 4'b0000, 3'b101, 3'b111, "ext1_fall_k1");
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b011, "ext1_rel_k");
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b011, "ext1_rel_k1");
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b111, "ext1_rel_k2");
        for (int k = 0; k < 4; k++) begin
            step(5'd0, 9'h000, 4'b0000, 3'b011, 3'b111, $sformatf("ext2_disabled_%0d", k));
        end
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b111, "ext2_disabled_rel");
        step(5'd0, 9'h000, 4'b0000, 3'b111, 3'b111, "ext_idle");

        // Scenario 4: IR bit conditions and microcode flags.
        for (int c = 1; c <= 7; c++) begin
            ir_v = 9'h001 << (c - 1);
            step(5'(c), ir_v,   4'b0000, 3'b111, 3'b011, $sformatf("ir_cond%0d_set", c));
            step(5'(c), 9'h000, 4'b1111, 3'b111, 3'b111, $sformatf("ir_cond%0d_zero", c));
            step(5'(c), ~ir_v,  4'b0000, 3'b111, 3'b111, $sformatf("ir_cond%0d_others", c));
        end
        step(5'd7,  9'h180, 4'b0000, 3'b111, 3'b111, "ir_upper_bits_c7");
        step(5'd15, 9'h180, 4'b1111, 3'b111, 3'b111, "ir_upper_bits_op2");
        step(5'd8,  9'h1ff, 4'b1111, 3'b111, 3'b111, "cond8_none");
        step(5'd9,  9'h1ff, 4'b1111, 3'b111, 3'b111, "cond9_none");
        step(5'd14, 9'h1ff, 4'b1111, 3'b111, 3'b111, "cond14_none");
        step(5'd0,  9'h1ff, 4'b1111, 3'b111, 3'b111, "cond0_none");
        step(5'd10, 9'h000, 4'b1110, 3'b111, 3'b111, "cond10_fv0");
        step(5'd10, 9'h000, 4'b0001, 3'b111, 3'b011, "cond10_fv1");
        step(5'd11, 9'h000, 4'b1101, 3'b111, 3'b111, "cond11_fl0");
        step(5'd11, 9'h000, 4'b0010, 3'b111, 3'b011, "cond11_fl1");
        step(5'd13, 9'h000, 4'b0111, 3'b111, 3'b111, "cond13_fn0");
        step(5'd13, 9'h000, 4'b1000, 3'b111, 3'b011, "cond13_fn1");
        for (int k = 0; k < 3; k++) begin
            step(5'd12, 9'h000, 4'b0100, 3'b111, 3'b011, $sformatf("fz_hi_%0d", k));
            step(5'd12, 9'h000, 4'b0000, 3'b111, 3'b111, $sformatf("fz_lo_%0d", k));
        end

        // Scenario 3: OP2 sweep, every ir[4:0] against every flag set.
        for (int i = 0; i < 32; i++) begin
            for (int f = 0; f < 16; f++) begin
                step(5'd15, 9'(i), 4'(f), 3'b111,
                     op2_rs(5'(i), 4'(f)) ? 3'b011 : 3'b111,
                     $sformatf("op2_ir%02h_f%01h", i, f));
            end
        end
        step(5'd15, 9'h001, 4'b0001, 3'b111, 3'b011, "op2_ir01_fv");
        step(5'd15, 9'h011, 4'b0001, 3'b111, 3'b111, "op2_ir11_fv");

        // Scenario 5: arm, accumulate, hold, clear; ex never sets sticky.
        step(5'd17, 9'h000, 4'b0000, 3'b111, 3'b110, "arm");
        step(5'd10, 9'h000, 4'b0001, 3'b111, 3'b000, "sticky_set");
        step(5'd10, 9'h000, 4'b0000, 3'b111, 3'b000, "sticky_hold0");
        step(5'd0,  9'h000, 4'b0000, 3'b111, 3'b000, "sticky_hold1");
        step(5'd16, 9'h000, 4'b0000, 3'b111, 3'b111, "clear");
        step(5'd10, 9'h000, 4'b0000, 3'b111, 3'b111, "after_clear");
        step(5'd10, 9'h000, 4'b0001, 3'b111, 3'b011, "unarmed_no_sticky");
        step(5'd0,  9'h000, 4'b0000, 3'b111, 3'b111, "unarmed_release");
        step(5'd17, 9'h000, 4'b0000, 3'b111, 3'b110, "arm_ex");
        step(5'd0,  9'h000, 4'b0000, 3'b110, 3'b110, "ex_armed_k");
        step(5'd0,  9'h000, 4'b0000, 3'b111, 3'b110, "ex_armed_k1");
        step(5'd0,  9'h000, 4'b0000, 3'b111, 3'b010, "ex_armed_k2");
        step(5'd0,  9'h000, 4'b0000, 3'b111, 3'b110, "ex_no_sticky");
        step(5'd16, 9'h000, 4'b0000, 3'b111, 3'b111, "clear_ex");

        // Scenario 6: reset pulse between edges while armed and sticky.
        step(5'd17, 9'h000, 4'b0000, 3'b111, 3'b110, "arm_rst");
        step(5'd10, 9'h000, 4'b0001, 3'b110, 3'b000, "sticky_rst");
        #2;
        nreset = 1'b0;
        #1;
        check_now(3'b111, "rst_mid_async");
        cond = 5'd10;
        {fn, fz, fl, fv} = 4'b0000;
        nskipext = 3'b111;
        #1;
        nreset = 1'b1;
        @(negedge clk4);
        step(5'd10, 9'h000, 4'b0000, 3'b111, 3'b111, "rst_mid_after0");
        step(5'd10, 9'h000, 4'b0000, 3'b111, 3'b111, "rst_mid_after1");

        for (int k = 0; k < 10 && sb.size() > 0; k++) begin
            @(negedge clk4);
        end
        if (sb.size() > 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/skip_unit_mc.md
SKIP_UNIT_MC -- requirements
Module: skip_unit_mc

Interface
REQ-001 Parameter: IRW, default 7, number of IR bits presented; legal range 7..16.
REQ-002 Parameter: NEXT, default 2, number of external skip request channels; legal range 1..8.
REQ-003 Parameter: SYNC, default 1; 1 = two-flop synchroniser on each external channel, 0 = single register stage.
REQ-004 Parameter: EXT_EN, default all ones (NEXT bits), per-channel enable; a disabled channel never causes a skip.
REQ-005 Port: clk4  input  1  clock; all state changes on the rising edge.
REQ-006 Port: nreset  input  1  asynchronous active-low reset.
REQ-007 Port: ir  input  IRW  instruction register bits.
REQ-008 Port: cond  input  5  microcode condition select.
REQ-009 Port: fn, fz, fl, fv  input  1 each  negative, zero, link and overflow flags.
REQ-010 Port: nskipext  input  NEXT  active-low external skip requests, asynchronous to clk4.
REQ-011 Port: nskip  output  1  registered active-low skip decision.
REQ-012 Port: nsticky  output  1  registered active-low sticky-skip status.
REQ-013 Port: narmed  output  1  registered active-low accumulate-mode status.

Function
REQ-014 The raw flag-skip term rs SHALL be combinational from cond, ir and the flags.
- cond 0: rs = 0.
- cond 1..7: rs = ir[cond-1].
- cond 10, 11, 12, 13: rs = fv, fl, fz, fn respectively.
- cond 15 (OP2 skip): rs = (|(ir[3:0] & {fn,fz,fl,fv})) XOR ir[4].
- cond 16 (CLEAR), cond 17 (ARM) and all other codes: rs = 0.
REQ-015 External request path: each nskipext bit passes through SYNC+1 register stages, reset value 1. The synchronised active term ex = OR over enabled channels of the inverted final stage.
REQ-016 A request sampled low at edge k SHALL drive nskip low after edge k+2 when SYNC=1, and after edge k+1 when SYNC=0.
REQ-017 The armed flag SHALL be set on an edge where cond=17 and cleared on an edge where cond=16; otherwise it holds.
REQ-018 The sticky flag SHALL be set on an edge where armed=1 and rs=1, and cleared on an edge where cond=16; otherwise it holds.
REQ-019 On the ARM edge itself, armed is 0 before the edge, so rs on that edge SHALL NOT set sticky.
REQ-020 CLEAR SHALL take precedence: on a cond=16 edge, sticky is 0 after the edge regardless of its prior value.
REQ-021 Sticky SHALL NOT be set by ex; only flag or IR conditions accumulate.
REQ-022 On every edge, nskip SHALL be registered as NOT(rs OR ex OR sticky_next), where sticky_next is the value sticky takes on that edge.
REQ-023 Latency: a flag or IR condition true before edge k SHALL make nskip low after edge k and high after the first later edge where the condition is false, provided sticky=0 and ex=0.
REQ-024 nsticky SHALL equal NOT sticky, and narmed SHALL equal NOT armed, both taken directly from their registers.
REQ-025 For IRW > 7, ir bits above ir[6] SHALL NOT affect any output.
REQ-026 Flag changes between edges SHALL NOT alter any output until the next edge.

Reset
REQ-027 While nreset=0, the block SHALL asynchronously force nskip=1, nsticky=1, narmed=1 and every synchroniser stage to 1, independent of clk4.
REQ-028 Reset asserted mid-operation SHALL discard armed, sticky and in-flight external requests.
REQ-029 After nreset rises, the first rising edge SHALL evaluate normally.
REQ-030 After nreset rises, a nskipext bit already held low SHALL appear on nskip only after the REQ-016 latency.

Verification
REQ-031 Scenario 1, reset: hold nreset=0 with nskipext=0 and cond=10, fv=1 -> nskip, nsticky and narmed stay 1; release reset -> nskip=0 after the first edge (flag path) while the external path follows the REQ-016 latency.
REQ-032 Scenario 2, external latency (SYNC=1): cond=0, nskipext[0] falls before edge k -> nskip=0 after edge k+2; release nskipext[0] -> nskip=1 two edges later; channel with EXT_EN bit 0 held low -> nskip stays 1.
REQ-033 Scenario 3, OP2 sweep: cond=15, all 32 values of ir[4:0] x all 16 flag combinations, one per cycle -> nskip matches REQ-014 one edge later (e.g. ir=0x01, fv=1 -> nskip=0; ir=0x11, fv=1 -> nskip=1).
REQ-034 Scenario 4, IR and microcode flags: cond=1..7 with ir = 1<<(cond-1) -> nskip=0; with ir=0 -> nskip=1; cond=12, fz toggling -> nskip tracks NOT fz with one-edge lag.
REQ-035 Scenario 5, sticky: cond=17 for one edge -> narmed=0; cond=10 with fv pulsed high for one cycle -> nsticky=0 and nskip remains 0 with fv=0; cond=16 -> nsticky=1, narmed=1, and nskip=1 on the same edge.
REQ-036 Scenario 6, reset mid-sticky: with armed and sticky set, pulse nreset low between edges -> all outputs 1 immediately; after release, cond=10 with fv=0 -> nskip=1.
